// File: rtl/membus_pkg.sv
// membus_pkg: shared types and widths for the PDP-6 memory bus initiator.
package membus_pkg;

  localparam int SEL_W  = 4;
  localparam int MA_W   = 15;
  localparam int WORD_W = 36;
  localparam int ADDR_W = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RDWAIT,
    S_RMWHOLD,
    S_WDATA,
    S_WRS,
    S_DONE
  } state_e;

  // Encoding is {write, read} so it can be built straight from the request bits.
  typedef enum logic [1:0] {
    RQ_NONE = 2'b00,
    RQ_RD   = 2'b01,
    RQ_WR   = 2'b10,
    RQ_RMW  = 2'b11
  } rq_type_e;

  function automatic logic type_has_rd(input rq_type_e t);
    return (t == RQ_RD) || (t == RQ_RMW);
  endfunction

  function automatic logic type_has_wr(input rq_type_e t);
    return (t == RQ_WR) || (t == RQ_RMW);
  endfunction

endpackage

// File: rtl/membus_wdog.sv
// membus_wdog: loadable down-counter; expire_o is high while enabled at zero.
// Only instantiated when MEMBUS_NXM_TIMEOUT_EN is defined.
module membus_wdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/membus_master.sv
// membus_master: CPU-side initiator for the PDP-6 memory bus. Runs one read,
// write or read-modify-write cycle at a time through the rq_cyc / addr_ack /
// rd_rs / wr_rs handshake. Optional macro MEMBUS_NXM_TIMEOUT_EN adds the
// nonexistent-memory timeout (nxm) on the ADDR and RDWAIT waits.
module membus_master
  import membus_pkg::*;
#(
  parameter int DATA_SETUP  = 2,
  parameter int ACK_TIMEOUT = 1000,
  parameter int RS_TIMEOUT  = 4000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         req_rd,
  input  logic         req_wr,
  input  logic [18:35] req_addr,
  input  logic [0:35]  wdata,
  input  logic         wr_go,
  output logic         busy,
  output logic         rd_done,
  output logic [0:35]  rdata,
  output logic         wr_done,
  output logic         nxm,
  output logic         membus_rq_cyc,
  output logic         membus_rd_rq,
  output logic         membus_wr_rq,
  output logic [18:21] membus_sel,
  output logic [21:35] membus_ma,
  output logic         membus_fmc_select,
  output logic [0:35]  membus_mb_out,
  output logic         membus_wr_rs,
  input  logic         membus_addr_ack,
  input  logic         membus_rd_rs,
  input  logic [0:35]  membus_mb_in
);

  localparam int WDOG_MAX = (ACK_TIMEOUT > RS_TIMEOUT) ? ACK_TIMEOUT : RS_TIMEOUT;
  localparam int WDOG_W   = $clog2(WDOG_MAX + 1);
  localparam logic [3:0] SETUP_LAST = 4'(DATA_SETUP - 1);

  state_e        state_q, state_d;
  rq_type_e      type_q;
  logic [18:35]  addr_q;
  logic [0:35]   wdata_q;
  logic [0:35]   rdata_q;
  logic [3:0]    setup_q;
  logic          rd_done_q, wr_done_q, nxm_q;

  logic              accept, rs_hit, timed_out;
  logic              wdog_load, wdog_en, wdog_expire;
  logic [WDOG_W-1:0] wdog_val;

  // Next-state decode; bus events are only honoured in the state expecting them.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    rs_hit    = 1'b0;
    timed_out = 1'b0;
    wdog_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && (req_rd || req_wr)) begin
          accept  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        wdog_en = 1'b1;
        if (membus_addr_ack) begin
          state_d = type_has_rd(type_q) ? S_RDWAIT : S_WDATA;
        end else if (wdog_expire) begin
          timed_out = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RDWAIT: begin
        wdog_en = 1'b1;
        if (membus_rd_rs) begin
          rs_hit  = 1'b1;
          state_d = (type_q == RQ_RMW) ? S_RMWHOLD : S_DONE;
        end else if (wdog_expire) begin
          timed_out = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RMWHOLD: if (wr_go) state_d = S_WDATA;
      S_WDATA:   if (setup_q == SETUP_LAST) state_d = S_WRS;
      S_WRS:     state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The watchdog is reloaded on entry to each timed wait.
  assign wdog_load = accept ||
                     ((state_q == S_ADDR) && membus_addr_ack && type_has_rd(type_q));
  assign wdog_val  = accept ? WDOG_W'(ACK_TIMEOUT - 1) : WDOG_W'(RS_TIMEOUT - 1);

`ifdef MEMBUS_NXM_TIMEOUT_EN
  membus_wdog #(.W(WDOG_W)) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .load_i     (wdog_load),
    .load_val_i (wdog_val),
    .en_i       (wdog_en),
    .expire_o   (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
  logic unused_wdog;
  assign unused_wdog = &{1'b0, wdog_load, wdog_en, wdog_val};
`endif

  // State, request latches, read accumulation and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      type_q    <= RQ_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      setup_q   <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      nxm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= rs_hit;
      wr_done_q <= (state_q == S_WRS);
      nxm_q     <= timed_out;
      if (accept) begin
        addr_q <= req_addr;
        type_q <= rq_type_e'({req_wr, req_rd});
        if (req_wr && !req_rd) wdata_q <= wdata;
        if (req_rd) rdata_q <= '0;
      end
      if (state_q == S_RDWAIT) rdata_q <= rdata_q | membus_mb_in;
      if ((state_q == S_RMWHOLD) && wr_go) wdata_q <= wdata;
      setup_q <= (state_q == S_WDATA) ? setup_q + 4'd1 : 4'd0;
    end
  end

  // Bus lines decode straight from the state so reset and state exits drop them at once.
  assign membus_rq_cyc     = (state_q == S_ADDR);
  assign membus_rd_rq      = (state_q == S_ADDR) && type_has_rd(type_q);
  assign membus_wr_rq      = (state_q == S_ADDR) && type_has_wr(type_q);
  assign membus_sel        = (state_q == S_ADDR) ? addr_q[18:21] : '0;
  assign membus_ma         = (state_q == S_ADDR) ? addr_q[21:35] : '0;
  assign membus_fmc_select = 1'b0;
  assign membus_mb_out     = ((state_q == S_WDATA) || (state_q == S_WRS)) ? wdata_q : '0;
  assign membus_wr_rs      = (state_q == S_WRS);

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rd_done = rd_done_q;
  assign wr_done = wr_done_q;
  assign nxm     = nxm_q;
  assign rdata   = rdata_q;

endmodule

// File: doc/membus_master.md
Name: membus_master

Overview:
- Processor-side initiator for the PDP-6 memory bus.
- Turns single CPU read, write or read-modify-write requests into the rq_cyc / addr_ack / rd_rs / wr_rs handshake that core memory modules respond to.
- Sits between the CPU memory-control logic and the bus. It drives select, address and data lines and captures OR-bus read data.
- Handles one outstanding cycle at a time.

Parameters:
- DATA_SETUP, 2, cycles write data is driven on mb_out before wr_rs rises (1..15).
- ACK_TIMEOUT, 1000, cycles to wait for addr_ack before declaring nonexistent memory.
- RS_TIMEOUT, 4000, cycles to wait for rd_rs after addr_ack.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  one-cycle request strobe from CPU; sampled only in IDLE
- req_rd  in  1  request includes read
- req_wr  in  1  request includes write; req_rd and req_wr together = read-modify-write
- req_addr  in  [18:35]  bits 18:21 select the module, bits 21:35 are the word address
- wdata  in  [0:35]  write data, sampled on req (write-only) or on wr_go (RMW)
- wr_go  in  1  RMW only: CPU supplies the modified word
- busy  out  1  high from accepted req until done/nxm
- rd_done  out  1  one-cycle pulse; rdata valid
- rdata  out  [0:35]  captured read word; holds until the next read starts
- wr_done  out  1  one-cycle pulse after the wr_rs cycle
- nxm  out  1  one-cycle pulse on timeout (feature only)
- membus_rq_cyc  out  1  cycle request
- membus_rd_rq  out  1  read request
- membus_wr_rq  out  1  write request
- membus_sel  out  [18:21]  module select
- membus_ma  out  [21:35]  address
- membus_fmc_select  out  1  tied 0
- membus_mb_out  out  [0:35]  write data to memory (zero when not driving)
- membus_wr_rs  out  1  write restart
- membus_addr_ack  in  1  address acknowledge pulse
- membus_rd_rs  in  1  read restart pulse
- membus_mb_in  in  [0:35]  OR-bus read data

Behaviour:
- Reset (async): state IDLE. All outputs 0, rdata cleared, counters cleared. Reset mid-cycle drops every bus line at once, with no done pulse.
- States: IDLE, ADDR, RDWAIT, RMWHOLD, WDATA, WRS, DONE.
- IDLE:
  - req with req_rd|req_wr: latch addr, type and (write-only) wdata; busy=1; go to ADDR next cycle.
  - req with neither bit set: ignored, busy stays 0.
  - req outside IDLE: ignored.
- ADDR: drive rq_cyc=1, sel, ma, rd_rq/wr_rq per type. On addr_ack, drop rq_cyc, rd_rq, wr_rq, sel and ma in the same edge (the memory has already latched them). Then:
  - read or RMW: go to RDWAIT; clear rdata when entering ADDR.
  - write-only: go to WDATA.
- RDWAIT: every cycle rdata <= rdata | membus_mb_in. On rd_rs, OR in mb_in that same cycle, then:
  - read-only: go to DONE with rd_done pulsed.
  - RMW: pulse rd_done and go to RMWHOLD.
- RMWHOLD: wait for wr_go indefinitely (no timeout). On wr_go, latch wdata and go to WDATA.
- WDATA: drive membus_mb_out=wdata for DATA_SETUP cycles, then go to WRS.
- WRS: keep mb_out; wr_rs=1 for exactly 1 cycle. Next cycle mb_out=0 and wr_rs=0; wr_done pulses; go to DONE.
- DONE: busy=0 and return to IDLE. A new req is accepted in the cycle after DONE. Minimum gap between bus cycles is 1 idle cycle.
- Write of an all-zero word is legal: mb_out stays 0, wr_rs still pulses.
- addr_ack or rd_rs outside the expecting state: ignored.
- rd_rs arriving in the same cycle as addr_ack: ignored. rd_rs only counts in RDWAIT.
- rd_done and wr_done never both pulse in one cycle.

Optional Feature:
- Macro MEMBUS_NXM_TIMEOUT_EN.
- With it: a cycle counter runs in ADDR (limit ACK_TIMEOUT) and RDWAIT (limit RS_TIMEOUT). On expiry:
  - all bus outputs go to 0 in the same edge;
  - nxm pulses 1 cycle;
  - rdata is left as accumulated;
  - busy drops and the state returns to IDLE.
- Without it: ADDR and RDWAIT wait forever, and nxm is tied 0.

Decomposition:
- membus_pkg: state enum, SEL/MA/WORD width constants, request type encoding (RD, WR, RMW).
- One sub-module, membus_wdog: loadable down-counter with expire pulse. Instantiated only under MEMBUS_NXM_TIMEOUT_EN.

Test Plan:
- Read: req_rd, addr 0o0100123 with sel matching; responder acks at +5 and drives mb_in=0o123456765432 then rd_rs at +20 -> rq_cyc drops on ack edge; rd_done pulses once; rdata=0o123456765432.
- Write-only: req_wr, wdata=0o777000777000, DATA_SETUP=2 -> after ack, mb_out valid 2 cycles, then wr_rs high exactly 1 cycle; wr_done; mb_out returns to 0.
- RMW: read returns 5; wr_go after 10 idle cycles with wdata=6 -> rd_done, rq lines low while waiting, then the write phase drives 6 and pulses wr_rs.
- Back-to-back: req held high across DONE -> second cycle starts with one IDLE gap; requests during busy produce no extra cycles.
- Timeout (feature on, ACK_TIMEOUT=16): no ack -> nxm at cycle 16, all bus outputs 0, busy 0. Feature off: busy stays 1 indefinitely.
- Async reset asserted mid-WDATA -> mb_out, wr_rs and busy 0 immediately; no wr_done.
